// File: rtl/fp_operand_loader_pkg.sv
// Shared definitions for the floating-point operand loader: entry-step
// encoding, operand field widths and the fraction capture rule.
// Optional feature macro: FP_LOADER_HIDDEN_BIT_EN (forces the normalized
// hidden bit into captured fractions).
package fp_operand_loader_pkg;

  localparam int EXP_W   = 4;
  localparam int FRAC_W  = 8;
  localparam int STATE_W = 3;

  // Entry steps; the encoding is also the value shown on the step display.
  typedef enum logic [STATE_W-1:0] {
    ST_F1   = 3'd0,
    ST_E1   = 3'd1,
    ST_F2   = 3'd2,
    ST_E2   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Fraction value stored when an enter event lands in a fraction step.
  function automatic logic [FRAC_W-1:0] capture_frac(input logic [7:0] sw);
`ifdef FP_LOADER_HIDDEN_BIT_EN
    return {1'b1, sw[6:0]};
`else
    return sw;
`endif
  endfunction

endpackage

// File: rtl/fp_operand_loader_if.sv
// Switch/button inputs and operand outputs of the operand loader.
interface fp_operand_loader_if;
  import fp_operand_loader_pkg::*;

  logic [1:0]        btn_amisha;
  logic [7:0]        sw_amisha;
  logic              sign1_amisha;
  logic              sign2_amisha;
  logic [EXP_W-1:0]  exp1_amisha;
  logic [EXP_W-1:0]  exp2_amisha;
  logic [FRAC_W-1:0] frac1_amisha;
  logic [FRAC_W-1:0] frac2_amisha;
  logic              valid_amisha;
  logic [STATE_W-1:0] step_amisha;

  // Board / stimulus side: drives buttons and switches, observes operands.
  modport master (
    output btn_amisha, sw_amisha,
    input  sign1_amisha, sign2_amisha, exp1_amisha, exp2_amisha,
    input  frac1_amisha, frac2_amisha, valid_amisha, step_amisha
  );

  // Loader side.
  modport slave (
    input  btn_amisha, sw_amisha,
    output sign1_amisha, sign2_amisha, exp1_amisha, exp2_amisha,
    output frac1_amisha, frac2_amisha, valid_amisha, step_amisha
  );
endinterface

// File: rtl/fp_operand_loader_db_edge.sv
// One pushbutton conditioner: 2-flop synchronizer, counting debouncer and a
// single-clock press pulse on the rising edge of the debounced level.
// The level flips on the 2^DB_W-th consecutive clock of disagreement; any
// clock of agreement clears the count.
module db_edge #(
  parameter int DB_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  logic            sync1_r;
  logic            sync2_r;
  logic            level_r;
  logic            press_r;
  logic [DB_W-1:0] count_r;
  logic            differ_s;
  logic            accept_s;

  // Disagreement detect and end-of-interval decode.
  always_comb begin
    differ_s = sync2_r ^ level_r;
    accept_s = differ_s && (count_r == {DB_W{1'b1}});
  end

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounce counter, accepted level and press pulse (pulse aligns with the
  // first clock the debounced level reads 1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {DB_W{1'b0}};
      level_r <= 1'b0;
      press_r <= 1'b0;
    end else if (!differ_s) begin
      count_r <= {DB_W{1'b0}};
      press_r <= 1'b0;
    end else if (accept_s) begin
      count_r <= {DB_W{1'b0}};
      level_r <= sync2_r;
      press_r <= sync2_r;
    end else begin
      count_r <= count_r + DB_W'(1);
      press_r <= 1'b0;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/fp_operand_loader.sv
// Floating-point operand loader: two debounced buttons (enter, clear) walk
// a four-step entry FSM that captures two sign/exponent/fraction operands
// from the slide switches.
// Optional feature macro: FP_LOADER_HIDDEN_BIT_EN (see package).
module fp_operand_loader
  import fp_operand_loader_pkg::*;
#(
  parameter int DB_W = 20
) (
  input  logic               clk_amisha,
  input  logic               reset_amisha,
  fp_operand_loader_if.slave bus
);

  logic              enter_s;
  logic              clear_s;
  state_t            state_r;
  state_t            next_s;
  logic              valid_r;
  logic              valid_next_s;
  logic              ld_frac1_s;
  logic              ld_exp1_s;
  logic              ld_frac2_s;
  logic              ld_exp2_s;
  logic              sign1_r;
  logic              sign2_r;
  logic [EXP_W-1:0]  exp1_r;
  logic [EXP_W-1:0]  exp2_r;
  logic [FRAC_W-1:0] frac1_r;
  logic [FRAC_W-1:0] frac2_r;

  db_edge #(.DB_W(DB_W)) u_enter (
    .clk     (clk_amisha),
    .rst     (reset_amisha),
    .btn_raw (bus.btn_amisha[0]),
    .press   (enter_s)
  );

  db_edge #(.DB_W(DB_W)) u_clear (
    .clk     (clk_amisha),
    .rst     (reset_amisha),
    .btn_raw (bus.btn_amisha[1]),
    .press   (clear_s)
  );

  // Next step, valid and operand load enables; clear overrides enter.
  always_comb begin
    next_s       = state_r;
    valid_next_s = valid_r;
    ld_frac1_s   = 1'b0;
    ld_exp1_s    = 1'b0;
    ld_frac2_s   = 1'b0;
    ld_exp2_s    = 1'b0;
    if (clear_s) begin
      next_s       = ST_F1;
      valid_next_s = 1'b0;
    end else if (enter_s) begin
      case (state_r)
        ST_F1: begin
          next_s     = ST_E1;
          ld_frac1_s = 1'b1;
        end
        ST_E1: begin
          next_s    = ST_F2;
          ld_exp1_s = 1'b1;
        end
        ST_F2: begin
          next_s     = ST_E2;
          ld_frac2_s = 1'b1;
        end
        ST_E2: begin
          next_s       = ST_DONE;
          ld_exp2_s    = 1'b1;
          valid_next_s = 1'b1;
        end
        ST_DONE: begin
          next_s = ST_DONE;
        end
        default: begin
          next_s       = ST_F1;
          valid_next_s = 1'b0;
        end
      endcase
    end else begin
      next_s = state_r;
    end
  end

  // Step register and registered valid flag.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      state_r <= ST_F1;
      valid_r <= 1'b0;
    end else begin
      state_r <= next_s;
      valid_r <= valid_next_s;
    end
  end

  // Operand registers; each field holds until its step is entered again.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      frac1_r <= {FRAC_W{1'b0}};
      sign1_r <= 1'b0;
      exp1_r  <= {EXP_W{1'b0}};
      frac2_r <= {FRAC_W{1'b0}};
      sign2_r <= 1'b0;
      exp2_r  <= {EXP_W{1'b0}};
    end else begin
      if (ld_frac1_s) begin
        frac1_r <= capture_frac(bus.sw_amisha);
      end
      if (ld_exp1_s) begin
        sign1_r <= bus.sw_amisha[7];
        exp1_r  <= bus.sw_amisha[EXP_W-1:0];
      end
      if (ld_frac2_s) begin
        frac2_r <= capture_frac(bus.sw_amisha);
      end
      if (ld_exp2_s) begin
        sign2_r <= bus.sw_amisha[7];
        exp2_r  <= bus.sw_amisha[EXP_W-1:0];
      end
    end
  end

  assign bus.step_amisha  = state_r;
  assign bus.valid_amisha = valid_r;
  assign bus.sign1_amisha = sign1_r;
  assign bus.exp1_amisha  = exp1_r;
  assign bus.frac1_amisha = frac1_r;
  assign bus.sign2_amisha = sign2_r;
  assign bus.exp2_amisha  = exp2_r;
  assign bus.frac2_amisha = frac2_r;

endmodule

// File: tb/tb_fp_operand_loader.sv
// Self-checking bench for fp_operand_loader with DB_W = 3 (8-clock debounce).
// A behavioural entry model pushes expected snapshots when a press is driven;
// DUT snapshots are queued once the press has settled and compared in order.
module tb_fp_operand_loader;

  localparam int HOLD = 14;

  typedef struct packed {
    logic [2:0] step;
    logic       valid;
    logic       sign1;
    logic [3:0] exp1;
    logic [7:0] frac1;
    logic       sign2;
    logic [3:0] exp2;
    logic [7:0] frac2;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  snap_t exp_q[$];
  snap_t obs_q[$];
  snap_t m;

  fp_operand_loader_if bus();

  fp_operand_loader #(.DB_W(3)) dut (
    .clk_amisha   (clk),
    .reset_amisha (rst),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_frac(input logic [7:0] sw);
`ifdef FP_LOADER_HIDDEN_BIT_EN
    return {1'b1, sw[6:0]};
`else
    return sw;
`endif
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.step  = bus.step_amisha;
    s.valid = bus.valid_amisha;
    s.sign1 = bus.sign1_amisha;
    s.exp1  = bus.exp1_amisha;
    s.frac1 = bus.frac1_amisha;
    s.sign2 = bus.sign2_amisha;
    s.exp2  = bus.exp2_amisha;
    s.frac2 = bus.frac2_amisha;
    return s;
  endfunction

  task automatic model_event(input logic enter, input logic clear, input logic [7:0] sw);
    if (clear) begin
      m.step  = 3'd0;
      m.valid = 1'b0;
    end else if (enter) begin
      case (m.step)
        3'd0: begin m.frac1 = exp_frac(sw); m.step = 3'd1; end
        3'd1: begin m.sign1 = sw[7]; m.exp1 = sw[3:0]; m.step = 3'd2; end
        3'd2: begin m.frac2 = exp_frac(sw); m.step = 3'd3; end
        3'd3: begin m.sign2 = sw[7]; m.exp2 = sw[3:0]; m.step = 3'd4; m.valid = 1'b1; end
        default: ;
      endcase
    end
  endtask

  // Full clean press/release of the selected buttons; records expected and observed.
  task automatic press(input logic [1:0] btns, input logic [7:0] sw);
    bus.sw_amisha  = sw;
    bus.btn_amisha = btns;
    model_event(btns[0], btns[1], sw);
    exp_q.push_back(m);
    repeat (HOLD) @(negedge clk);
    bus.btn_amisha = 2'b00;
    repeat (HOLD) @(negedge clk);
    obs_q.push_back(dut_snap());
  endtask

  task automatic test_reset();
    bus.btn_amisha = 2'b00;
    bus.sw_amisha  = 8'h00;
    m = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (dut_snap() !== m) begin
      tests_failed++;
      $display("FAIL reset_state: got %h, expected %h", dut_snap(), m);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sequence();
    snap_t e, o;
    // First enter done by hand to pin the latency: press pulse on the 10th
    // clock after the raw edge, operand visible after the 11th.
    bus.sw_amisha  = 8'hA5;
    bus.btn_amisha = 2'b01;
    repeat (10) @(negedge clk);
    tests_run++;
    if (bus.step_amisha !== 3'd0) begin
      tests_failed++;
      $display("FAIL latency_early: got step=%0d, expected step=0", bus.step_amisha);
    end
    @(negedge clk);
    tests_run++;
    if (bus.step_amisha !== 3'd1 || bus.frac1_amisha !== exp_frac(8'hA5)) begin
      tests_failed++;
      $display("FAIL latency_update: got step=%0d frac1=%h, expected step=1 frac1=%h",
               bus.step_amisha, bus.frac1_amisha, exp_frac(8'hA5));
    end
    bus.btn_amisha = 2'b00;
    repeat (HOLD) @(negedge clk);
    model_event(1'b1, 1'b0, 8'hA5);
    exp_q.push_back(m);
    obs_q.push_back(dut_snap());

    press(2'b01, 8'h83);
    press(2'b01, 8'h3C);
    press(2'b01, 8'h07);
    tests_run++;
    if (bus.valid_amisha !== 1'b1 || bus.step_amisha !== 3'd4 || bus.exp1_amisha !== 4'h3 ||
        bus.sign1_amisha !== 1'b1 || bus.exp2_amisha !== 4'h7 || bus.sign2_amisha !== 1'b0 ||
        bus.frac1_amisha !== 8'hA5) begin
      tests_failed++;
      $display("FAIL full_entry: got step=%0d valid=%b s1=%b e1=%h f1=%h s2=%b e2=%h, expected step=4 valid=1 s1=1 e1=3 f1=a5 s2=0 e2=7",
               bus.step_amisha, bus.valid_amisha, bus.sign1_amisha, bus.exp1_amisha,
               bus.frac1_amisha, bus.sign2_amisha, bus.exp2_amisha);
    end
    press(2'b01, 8'hFF);   // ignored in DONE
    press(2'b10, 8'hFF);   // clear from DONE
    press(2'b01, 8'h12);   // hidden-bit capture case
    tests_run++;
`ifdef FP_LOADER_HIDDEN_BIT_EN
    if (bus.frac1_amisha !== 8'h92) begin
      tests_failed++;
      $display("FAIL hidden_bit: got frac1=%h, expected frac1=92", bus.frac1_amisha);
    end
`else
    if (bus.frac1_amisha !== 8'h12) begin
      tests_failed++;
      $display("FAIL hidden_bit: got frac1=%h, expected frac1=12", bus.frac1_amisha);
    end
`endif
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL sequence_step: got %h, expected %h", o, e);
      end
    end
  endtask

  task automatic test_bounce();
    snap_t e, o;
    // Currently in E1: bounce must not advance, stable press advances once.
    bus.sw_amisha  = 8'h85;
    bus.btn_amisha = 2'b00;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) bus.btn_amisha[0] = ~bus.btn_amisha[0];
      @(negedge clk);
    end
    bus.btn_amisha = 2'b00;
    repeat (4) @(negedge clk);
    tests_run++;
    if (bus.step_amisha !== 3'd1) begin
      tests_failed++;
      $display("FAIL bounce_hold: got step=%0d, expected step=1", bus.step_amisha);
    end
    press(2'b01, 8'h85);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL bounce_advance: got %h, expected %h", o, e);
      end
    end
  endtask

  task automatic test_same_clock();
    snap_t e, o;
    press(2'b01, 8'h44);   // F2 -> E2
    press(2'b11, 8'h0E);   // clear and enter together: clear wins
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL clear_wins: got %h, expected %h", o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    snap_t e, o;
    press(2'b01, 8'h11);
    press(2'b01, 8'h82);   // now in F2
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL reach_f2: got %h, expected %h", o, e);
      end
    end
    // Start a press, then reset asynchronously between clock edges.
    bus.sw_amisha  = 8'h99;
    bus.btn_amisha = 2'b01;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    m = '0;
    tests_run++;
    if (dut_snap() !== m) begin
      tests_failed++;
      $display("FAIL async_reset: got %h, expected %h", dut_snap(), m);
    end
    // Button held through reset release: needs a full interval again.
    @(negedge clk);
    rst = 1'b0;
    repeat (9) @(negedge clk);
    tests_run++;
    if (bus.step_amisha !== 3'd0) begin
      tests_failed++;
      $display("FAIL held_early: got step=%0d, expected step=0", bus.step_amisha);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.step_amisha !== 3'd1 || bus.frac1_amisha !== exp_frac(8'h99)) begin
      tests_failed++;
      $display("FAIL held_press: got step=%0d frac1=%h, expected step=1 frac1=%h",
               bus.step_amisha, bus.frac1_amisha, exp_frac(8'h99));
    end
    bus.btn_amisha = 2'b00;
    repeat (HOLD) @(negedge clk);
    // Reset with the button released: no event afterwards.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    tests_run++;
    if (dut_snap() !== m) begin
      tests_failed++;
      $display("FAIL no_spurious_event: got %h, expected %h", dut_snap(), m);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_bounce();
    test_same_clock();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
